pipeline_interlock: RTL and testbench
=====================================

# pipeline_interlock

Hazard and sequencing controller for the 5-stage CPU pipeline (IF, ID, EX, MEM, WB). The pipeline has no forwarding, so this block keeps a scoreboard of in-flight destination registers and stalls dependent instructions in ID. It also holds EX for extra cycles while the multiplier result settles, and freezes the whole pipeline on an external wait request. It drives the hold and bubble enables of the PC, IF/ID, ID/EX (A, B, IMM, CTRL1) and EX/MEM (D, B2, CTRL2) registers.

## Interface
Parameters:
- MUL_EXTRA, 2: extra EX cycles a multiply occupies (0 = single-cycle, no MUL_WAIT state).
- CNT_W, 16: width of the stall performance counter.

Ports:
- CLK  in  1  system clock (CLK_SYS domain); single clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- freeze  in  1  external wait (bus not ready); holds every pipeline register.
- id_valid  in  1  ID holds a real instruction.
- id_a_reg, id_b_reg  in  5 each  source registers decoded in ID.
- id_uses_a, id_uses_b  in  1 each  the source is actually read.
- id_wr_en  in  1  instruction in ID writes back.
- id_wr_reg  in  5  destination register of ID instruction.
- id_is_mul  in  1  instruction in ID selects the multiplier path.
- stall_if_id  out  1  hold PC and IF/ID.
- hold_ex  out  1  hold ID/EX registers (takes priority over bubble_ex).
- bubble_ex  out  1  load NOP (ctrl = 0) into ID/EX.
- bubble_mem  out  1  load NOP into EX/MEM.
- hold_all  out  1  hold every pipeline register, including MEM/WB.
- mul_busy  out  1  the block is in MUL_WAIT.
- stall_cnt  out  CNT_W  saturating count of hazard plus mul stall cycles.

## Operation
- Scoreboard: three slots, EX, MEM and WB. Each slot holds {valid, reg[4:0]}. Register 0 is never entered (valid forced to 0).
- hazard = id_valid & ((id_uses_a & id_a_reg≠0 & id_a_reg matches any valid slot) | (same for b)).
- States: RUN and MUL_WAIT. A counter mcnt is loaded with MUL_EXTRA.
- Priority of conditions: freeze, then MUL_WAIT, then hazard, then normal.
- freeze = 1:
  - hold_all = stall_if_id = hold_ex = 1; bubbles = 0.
  - Scoreboard, mcnt, state and stall_cnt are unchanged.
- MUL_WAIT (freeze = 0):
  - stall_if_id = hold_ex = bubble_mem = 1.
  - Scoreboard: EX slot is kept, MEM ← invalid, WB ← old MEM.
  - mcnt decrements. When mcnt = 1, the next state is RUN.
- RUN with hazard:
  - stall_if_id = bubble_ex = 1.
  - EX slot ← invalid, MEM ← EX, WB ← MEM.
- RUN, no hazard:
  - All control outputs are 0.
  - EX ← {id_valid & id_wr_en & id_wr_reg≠0, id_wr_reg}, MEM ← EX, WB ← MEM.
  - If id_valid & id_is_mul & MUL_EXTRA > 0: go to MUL_WAIT and set mcnt = MUL_EXTRA.
- stall_cnt increments on every non-freeze cycle with stall_if_id = 1. It saturates at all-ones.

## Timing
- All control outputs are combinational from the current state and ID inputs, and valid in the same cycle. Scoreboard, state, mcnt and stall_cnt update at the rising edge.
- Reset values:
  - All slots invalid, state RUN, mcnt = 0, stall_cnt = 0.
  - Therefore all outputs are 0 during and right after reset, provided id_valid = 0.
- Back-to-back dependency (WB not bypassed): the consumer stalls 3 cycles. The consumer's operands are read in the cycle after the producer's WB.
- Producer two instructions ahead: 2 stalls. Three ahead: 1 stall. Four or more ahead: 0 stalls.
- A multiply adds exactly MUL_EXTRA stall cycles. Hazard checks are not evaluated during MUL_WAIT.
- Freeze during MUL_WAIT or a hazard stall extends it one-for-one. mcnt is not consumed.
- An RST asserted mid-MUL_WAIT returns the block to RUN at the next edge and clears the scoreboard.

## Configuration
- WB_BYPASS_EN defined:
  - The register file is write-through, so the WB slot is excluded from the hazard compare.
  - Back-to-back dependency then costs 2 stalls. The WB slot is still tracked internally.
- Not defined: all three slots are compared.

## Test plan
- Reset, then id_valid = 0 for 5 cycles -> all outputs 0, stall_cnt = 0.
- Producer writes r5, then consumer reads r5 (id_uses_a) -> stall_if_id = bubble_ex = 1 for 3 cycles and 0 on the 4th; stall_cnt = 3. With WB_BYPASS_EN: 2 cycles.
- Producer writes r0, then consumer reads r0 -> no stall. A producer with id_wr_en = 0 to r7 followed by a consumer of r7 -> no stall.
- MUL (MUL_EXTRA = 2) followed by an independent instruction -> mul_busy, hold_ex and bubble_mem = 1 for exactly 2 cycles; stall_cnt = 2.
- Hazard on r3 with freeze pulsed for 2 cycles during the 2nd stall cycle -> hold_all = 1 for those 2 cycles; total stall_if_id span = 5 cycles; stall_cnt = 3.
- RST asserted during MUL_WAIT, then a consumer of the mul's destination register -> no stall after reset; stall_cnt = 0.

Source files
------------

// File: rtl/pipeline_interlock.sv
// Hazard/sequencing controller for the 5-stage no-forwarding pipeline: scoreboard stall, multiply hold, freeze.
// Optional build macro WB_BYPASS_EN: write-through register file, WB slot excluded from the hazard compare.
module pipeline_interlock #(
  parameter int MUL_EXTRA = 2,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic [4:0]       id_a_reg,
  input  logic [4:0]       id_b_reg,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wr_reg,
  input  logic             id_is_mul,
  output logic             stall_if_id,
  output logic             hold_ex,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             hold_all,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MCNT_W = (MUL_EXTRA < 2) ? 1 : $clog2(MUL_EXTRA + 1);
  localparam logic [MCNT_W-1:0] MCNT_LOAD = MCNT_W'(MUL_EXTRA);

`ifdef WB_BYPASS_EN
  localparam logic [2:0] CMP_MASK = 3'b011;
`else
  localparam logic [2:0] CMP_MASK = 3'b111;
`endif

  typedef enum logic {ST_RUN, ST_MUL_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [MCNT_W-1:0] r_mcnt;
  logic [MCNT_W-1:0] w_mcnt_next;
  logic [CNT_W-1:0]  r_stall_cnt;

  // Slot index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0] r_slot_v;
  logic [2:0] w_slot_v_next;
  logic [4:0] r_slot_reg [3];
  logic [4:0] w_slot_reg_next [3];

  logic [2:0] w_match_a;
  logic [2:0] w_match_b;
  logic       w_hazard;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
      assign w_match_a[gi] = r_slot_v[gi] && (r_slot_reg[gi] == id_a_reg);
      assign w_match_b[gi] = r_slot_v[gi] && (r_slot_reg[gi] == id_b_reg);
    end
  endgenerate

  assign w_hazard = id_valid &&
                    ((id_uses_a && (id_a_reg != 5'd0) && |(w_match_a & CMP_MASK)) ||
                     (id_uses_b && (id_b_reg != 5'd0) && |(w_match_b & CMP_MASK)));

  always_comb begin
    stall_if_id     = 1'b0;
    hold_ex         = 1'b0;
    bubble_ex       = 1'b0;
    bubble_mem      = 1'b0;
    hold_all        = 1'b0;
    mul_busy        = (r_state == ST_MUL_WAIT);
    w_state_next    = r_state;
    w_mcnt_next     = r_mcnt;
    w_slot_v_next   = r_slot_v;
    w_slot_reg_next = r_slot_reg;
    if (freeze) begin
      hold_all    = 1'b1;
      stall_if_id = 1'b1;
      hold_ex     = 1'b1;
    end else if (r_state == ST_MUL_WAIT) begin
      stall_if_id        = 1'b1;
      hold_ex            = 1'b1;
      bubble_mem         = 1'b1;
      // The multiply stays in EX; only the slots behind it drain.
      w_slot_v_next      = {r_slot_v[1], 1'b0, r_slot_v[0]};
      w_slot_reg_next[2] = r_slot_reg[1];
      w_mcnt_next        = r_mcnt - 1'b1;
      if (r_mcnt == MCNT_W'(1)) begin
        w_state_next = ST_RUN;
      end
    end else if (w_hazard) begin
      stall_if_id        = 1'b1;
      bubble_ex          = 1'b1;
      w_slot_v_next      = {r_slot_v[1], r_slot_v[0], 1'b0};
      w_slot_reg_next[2] = r_slot_reg[1];
      w_slot_reg_next[1] = r_slot_reg[0];
    end else begin
      w_slot_v_next      = {r_slot_v[1], r_slot_v[0],
                            id_valid && id_wr_en && (id_wr_reg != 5'd0)};
      w_slot_reg_next[2] = r_slot_reg[1];
      w_slot_reg_next[1] = r_slot_reg[0];
      w_slot_reg_next[0] = id_wr_reg;
      if (id_valid && id_is_mul && (MUL_EXTRA > 0)) begin
        w_state_next = ST_MUL_WAIT;
        w_mcnt_next  = MCNT_LOAD;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_RUN;
      r_mcnt      <= '0;
      r_stall_cnt <= '0;
      r_slot_v    <= '0;
      for (int i = 0; i < 3; i++) begin
        r_slot_reg[i] <= 5'd0;
      end
    end else begin
      r_state  <= w_state_next;
      r_mcnt   <= w_mcnt_next;
      r_slot_v <= w_slot_v_next;
      for (int i = 0; i < 3; i++) begin
        r_slot_reg[i] <= w_slot_reg_next[i];
      end
      if (!freeze && stall_if_id && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_interlock.sv
// Bench for pipeline_interlock: directed vector table, then random stimulus against a slot-list reference model.
module tb_pipeline_interlock;

  localparam int MUL_EXTRA = 2;
  localparam int CNT_W     = 4;
`ifdef WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int S3   = 1 - BYP;
  localparam int NCMP = 3 - BYP;

  logic             CLK = 1'b0;
  logic             RST, freeze, id_valid, id_uses_a, id_uses_b, id_wr_en, id_is_mul;
  logic [4:0]       id_a_reg, id_b_reg, id_wr_reg;
  logic             stall_if_id, hold_ex, bubble_ex, bubble_mem, hold_all, mul_busy;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  pipeline_interlock #(.MUL_EXTRA(MUL_EXTRA), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .freeze(freeze), .id_valid(id_valid),
    .id_a_reg(id_a_reg), .id_b_reg(id_b_reg), .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_mul(id_is_mul),
    .stall_if_id(stall_if_id), .hold_ex(hold_ex), .bubble_ex(bubble_ex),
    .bubble_mem(bubble_mem), .hold_all(hold_all), .mul_busy(mul_busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit         chk;
    bit         rst, frz, v;
    logic [4:0] a;
    bit         ua;
    logic [4:0] b;
    bit         ub, we;
    logic [4:0] wr;
    bit         mul;
    logic [9:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(bit chk, bit rst, bit frz, bit v, int a, bit ua, int b, bit ub,
                              bit we, int wr, bit mul, bit st, bit hx, bit bx, bit bm,
                              bit ha, bit bz, int cnt);
    vec_t r;
    r.chk = chk; r.rst = rst; r.frz = frz; r.v = v;
    r.a = 5'(a); r.ua = ua; r.b = 5'(b); r.ub = ub;
    r.we = we; r.wr = 5'(wr); r.mul = mul;
    r.exp = {st, hx, bx, bm, ha, bz, 4'(cnt)};
    return r;
  endfunction

  function automatic logic [9:0] dut_out();
    return {stall_if_id, hold_ex, bubble_ex, bubble_mem, hold_all, mul_busy, stall_cnt};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {st,hx,bx,bm,ha,busy,cnt}=%b_%h required %b_%h",
               name, act[9:4], act[3:0], exp[9:4], exp[3:0]);
    end
  endtask

  task automatic drive(input bit rst, input bit frz, input bit v, input logic [4:0] a, input bit ua,
                       input logic [4:0] b, input bit ub, input bit we, input logic [4:0] wr,
                       input bit mul);
    RST = rst; freeze = frz; id_valid = v; id_a_reg = a; id_uses_a = ua;
    id_b_reg = b; id_uses_b = ub; id_wr_en = we; id_wr_reg = wr; id_is_mul = mul;
  endtask

  // Reference model: list of in-flight destinations (-1 = empty), [0]=EX [1]=MEM [2]=WB.
  int m_pipe[3];
  int m_mul_left;
  int m_cnt;

  function automatic bit model_hazard();
    bit h = 1'b0;
    for (int k = 0; k < NCMP; k++) begin
      if (m_pipe[k] > 0 && id_valid &&
          ((id_uses_a && int'(id_a_reg) == m_pipe[k]) || (id_uses_b && int'(id_b_reg) == m_pipe[k])))
        h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [9:0] model_out();
    bit st = 0, hx = 0, bx = 0, bm = 0, ha = 0;
    if (freeze) begin
      st = 1; hx = 1; ha = 1;
    end else if (m_mul_left > 0) begin
      st = 1; hx = 1; bm = 1;
    end else if (model_hazard()) begin
      st = 1; bx = 1;
    end
    return {st, hx, bx, bm, ha, m_mul_left > 0, 4'(m_cnt)};
  endfunction

  task automatic model_step();
    if (RST) begin
      m_pipe = '{-1, -1, -1};
      m_mul_left = 0;
      m_cnt = 0;
    end else if (!freeze) begin
      if (m_mul_left > 0) begin
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = -1;
        m_mul_left--;
        m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
      end else if (model_hazard()) begin
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = -1;
        m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
      end else begin
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = (id_valid && id_wr_en && id_wr_reg != 5'd0) ? int'(id_wr_reg) : -1;
        if (id_valid && id_is_mul && MUL_EXTRA > 0) m_mul_left = MUL_EXTRA;
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset then idle.
    vq.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    // Back-to-back dependency on r5.
    vq.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,0,0,0,0, 1,5,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,5,1,0,0, 0,0,0, 1,0,1,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,5,1,0,0, 0,0,0, 1,0,1,0,0,0, 1));
    vq.push_back(mk(1,0,0, 1,5,1,0,0, 0,0,0, S3,0,S3,0,0,0, 2));
    vq.push_back(mk(1,0,0, 1,5,1,0,0, 0,0,0, 0,0,0,0,0,0, 2+S3));
    vq.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 2+S3));
    // r0 producer and non-writing producer never create hazards.
    vq.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,0,0,0,0, 1,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,0,1,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,0,0,0,0, 0,7,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,0,0,7,1, 0,0,0, 0,0,0,0,0,0, 0));
    // Multiply then independent instruction.
    vq.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,0,0,0,0, 1,9,1, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,1,1,0,0, 0,0,0, 1,1,0,1,0,1, 0));
    vq.push_back(mk(1,0,0, 1,1,1,0,0, 0,0,0, 1,1,0,1,0,1, 1));
    vq.push_back(mk(1,0,0, 1,1,1,0,0, 0,0,0, 0,0,0,0,0,0, 2));
    vq.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 2));
    // Hazard on r3 with freeze during the second stall cycle.
    vq.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,0,0,0,0, 1,3,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,3,1,0,0, 0,0,0, 1,0,1,0,0,0, 0));
    vq.push_back(mk(1,0,1, 1,3,1,0,0, 0,0,0, 1,1,0,0,1,0, 1));
    vq.push_back(mk(1,0,1, 1,3,1,0,0, 0,0,0, 1,1,0,0,1,0, 1));
    vq.push_back(mk(1,0,0, 1,3,1,0,0, 0,0,0, 1,0,1,0,0,0, 1));
    vq.push_back(mk(1,0,0, 1,3,1,0,0, 0,0,0, S3,0,S3,0,0,0, 2));
    vq.push_back(mk(1,0,0, 1,3,1,0,0, 0,0,0, 0,0,0,0,0,0, 2+S3));
    // Reset in MUL_WAIT clears the multiply and its scoreboard entry.
    vq.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,0,0,0,0, 1,4,1, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 1,1,0,1,0,1, 0));
    vq.push_back(mk(0,1,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 1,4,1,0,0, 0,0,0, 0,0,0,0,0,0, 0));
    vq.push_back(mk(1,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge CLK); #1;
      drive(vq[i].rst, vq[i].frz, vq[i].v, vq[i].a, vq[i].ua, vq[i].b, vq[i].ub,
            vq[i].we, vq[i].wr, vq[i].mul);
      @(negedge CLK);
      if (vq[i].chk) begin
        check($sformatf("vec%0d", i), dut_out(), vq[i].exp);
        $display("vec %0d: out=%b_%h exp=%b_%h", i, dut_out() >> 4, stall_cnt,
                 vq[i].exp >> 4, vq[i].exp[3:0]);
      end
    end

    // Random phase; the first cycle is a reset that aligns model and DUT.
    m_pipe = '{-1, -1, -1};
    m_mul_left = 0;
    m_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      drive((i == 0) || ($urandom_range(99) == 0), $urandom_range(9) == 0,
            $urandom_range(3) != 0, 5'($urandom_range(7)), 1'($urandom_range(1)),
            5'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
            5'($urandom_range(7)), $urandom_range(6) == 0);
      @(negedge CLK);
      if (i > 0) begin
        check($sformatf("rand%0d", i), dut_out(), model_out());
        if (i % 250 == 0)
          $display("rand %0d: out=%b_%h", i, dut_out() >> 4, stall_cnt);
      end
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
